// File: rtl/bip_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bip_sequencer_if : sequencer <-> program memory / data RAM / datapath bundle
// Revision: 1.0
// ---------------------------------------------------------------------------
interface bip_sequencer_if #(
  parameter int PC_W  = 11,
  parameter int OPC_W = 5,
  parameter int CNT_W = 32
);
  logic                    start;
  logic [OPC_W+PC_W-1:0]   instr_data;
  logic [PC_W-1:0]         address_output;
  logic [PC_W-1:0]         data_addr;
  logic [PC_W-1:0]         operand;
  logic [1:0]              sel_a;
  logic                    op_sub;
  logic                    wr_acc;
  logic                    wr_ram;
  logic                    halted;
  logic [CNT_W-1:0]        cycle_count;

  modport master (
    input  start, instr_data,
    output address_output, data_addr, operand, sel_a, op_sub,
           wr_acc, wr_ram, halted, cycle_count
  );

  modport slave (
    output start, instr_data,
    input  address_output, data_addr, operand, sel_a, op_sub,
           wr_acc, wr_ram, halted, cycle_count
  );
endinterface
`default_nettype wire

// File: rtl/bip_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bip_sequencer : multi-cycle fetch/decode/execute control unit for BIP
// Revision: 1.0
// ---------------------------------------------------------------------------
module bip_sequencer #(
  parameter int PC_W  = 11,
  parameter int OPC_W = 5,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  bip_sequencer_if.master bus
);

  localparam int IW = OPC_W + PC_W;

  localparam logic [OPC_W-1:0] OP_HLT  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_STO  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_SUBI = OPC_W'(7);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_OPERAND = 3'd3,
    S_EXEC    = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [IW-1:0]    ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_a_q, sel_a_d;
  logic             op_sub_q, op_sub_d;
  logic             wr_acc_q, wr_acc_d;
  logic             wr_ram_q, wr_ram_d;

  logic [OPC_W-1:0] dec_opc;
  logic             enter_exec;
  logic             running;

  // Strobes are registered, so the opcode must be known on the edge entering
  // EXEC: straight from memory when DECODE jumps to EXEC, else from IR.
  assign dec_opc = (state_q == S_DECODE) ? bus.instr_data[IW-1:PC_W]
                                         : ir_q[IW-1:PC_W];

  assign running = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                   (state_q == S_OPERAND) || (state_q == S_EXEC);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    cnt_d      = cnt_q;
    sel_a_d    = sel_a_q;
    op_sub_d   = op_sub_q;
    wr_acc_d   = 1'b0;
    wr_ram_d   = 1'b0;
    enter_exec = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ir_d = bus.instr_data;
        if (dec_opc == OP_LD || dec_opc == OP_ADD || dec_opc == OP_SUB) begin
          state_d = S_OPERAND;
        end else begin
          state_d    = S_EXEC;
          enter_exec = 1'b1;
        end
      end
      S_OPERAND: begin
        state_d    = S_EXEC;
        enter_exec = 1'b1;
      end
      S_EXEC: begin
        if (ir_q[IW-1:PC_W] == OP_HLT) begin
          state_d = S_HALT;
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (enter_exec) begin
      case (dec_opc)
        OP_STO: wr_ram_d = 1'b1;
        OP_LD: begin
          wr_acc_d = 1'b1;
          sel_a_d  = 2'd0;
        end
        OP_LDI: begin
          wr_acc_d = 1'b1;
          sel_a_d  = 2'd1;
        end
        OP_ADD, OP_ADDI: begin
          wr_acc_d = 1'b1;
          sel_a_d  = 2'd2;
          op_sub_d = 1'b0;
        end
        OP_SUB, OP_SUBI: begin
          wr_acc_d = 1'b1;
          sel_a_d  = 2'd2;
          op_sub_d = 1'b1;
        end
        default: ;
      endcase
    end

    if (running && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      cnt_q    <= '0;
      sel_a_q  <= 2'd0;
      op_sub_q <= 1'b0;
      wr_acc_q <= 1'b0;
      wr_ram_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      cnt_q    <= cnt_d;
      sel_a_q  <= sel_a_d;
      op_sub_q <= op_sub_d;
      wr_acc_q <= wr_acc_d;
      wr_ram_q <= wr_ram_d;
    end
  end

  assign bus.address_output = pc_q;
  assign bus.data_addr      = ir_q[PC_W-1:0];
  assign bus.operand        = ir_q[PC_W-1:0];
  assign bus.sel_a          = sel_a_q;
  assign bus.op_sub         = op_sub_q;
  assign bus.wr_acc         = wr_acc_q;
  assign bus.wr_ram         = wr_ram_q;
  assign bus.halted         = (state_q == S_HALT);
  assign bus.cycle_count    = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bip_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bip_sequencer : directed self-checking bench for bip_sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_bip_sequencer;

  localparam int PC_W  = 11;
  localparam int OPC_W = 5;
  localparam int CNT_W = 32;

  logic clk;
  logic rst_n;

  bip_sequencer_if #(.PC_W(PC_W), .OPC_W(OPC_W), .CNT_W(CNT_W)) bus ();

  bip_sequencer #(.PC_W(PC_W), .OPC_W(OPC_W), .CNT_W(CNT_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  logic [15:0] mem [0:2047];

  always @(posedge clk) bus.instr_data <= mem[bus.address_output];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] acc_m, ram_m, halt_m;
  logic [1:0]  sel_tr [0:31];
  logic        sub_tr [0:31];
  logic [10:0] da_tr  [0:31];
  logic [10:0] ad_tr  [0:31];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ins(input logic [4:0] opc, input logic [10:0] opd);
    return {opc, opd};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
  endtask

  // Start a run and record cycles 1..n (cycle 1 = FETCH of the first instruction).
  task automatic run_trace(input int n);
    acc_m  = '0;
    ram_m  = '0;
    halt_m = '0;
    bus.start = 1'b1;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (k == 1) bus.start = 1'b0;
      acc_m[k]  = bus.wr_acc;
      ram_m[k]  = bus.wr_ram;
      halt_m[k] = bus.halted;
      sel_tr[k] = bus.sel_a;
      sub_tr[k] = bus.op_sub;
      da_tr[k]  = bus.data_addr;
      ad_tr[k]  = bus.address_output;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic seen;
    int   wait_cnt;

    rst_n     = 1'b0;
    bus.start = 1'b0;
    clear_mem();
    #2;

    // Idle after reset
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    check_val("idle_addr",   bus.address_output, 0);
    check_val("idle_wr_acc", bus.wr_acc, 0);
    check_val("idle_wr_ram", bus.wr_ram, 0);
    check_val("idle_count",  bus.cycle_count, 0);
    check_val("idle_halted", bus.halted, 0);
    check_val("idle_sel_a",  bus.sel_a, 0);
    check_val("idle_op_sub", bus.op_sub, 0);

    // LDI 5; ADDI 3; HLT
    clear_mem();
    mem[0] = ins(5'b00011, 11'd5);
    mem[1] = ins(5'b00101, 11'd3);
    mem[2] = ins(5'b00000, 11'd0);
    do_reset();
    run_trace(12);
    check_val("p1_acc_mask",  acc_m, 32'h0000_0048);
    check_val("p1_ram_mask",  ram_m, 32'h0);
    check_val("p1_halt_mask", halt_m, 32'h0000_1C00);
    check_val("p1_sel_c3",    sel_tr[3], 1);
    check_val("p1_sel_c6",    sel_tr[6], 2);
    check_val("p1_sub_c6",    sub_tr[6], 0);
    check_val("p1_count",     bus.cycle_count, 9);
    check_val("p1_addr",      bus.address_output, 2);

    // LD 7; SUB 8; STO 9; HLT
    clear_mem();
    mem[0] = ins(5'b00010, 11'd7);
    mem[1] = ins(5'b00110, 11'd8);
    mem[2] = ins(5'b00001, 11'd9);
    mem[3] = ins(5'b00000, 11'd0);
    do_reset();
    run_trace(16);
    check_val("p2_acc_mask", acc_m, 32'h0000_0110);
    check_val("p2_ram_mask", ram_m, 32'h0000_0800);
    check_val("p2_da_c3",    da_tr[3], 7);
    check_val("p2_da_c4",    da_tr[4], 7);
    check_val("p2_sel_c4",   sel_tr[4], 0);
    check_val("p2_sub_c8",   sub_tr[8], 1);
    check_val("p2_sel_c8",   sel_tr[8], 2);
    check_val("p2_da_c11",   da_tr[11], 9);
    check_val("p2_count",    bus.cycle_count, 14);
    check_val("p2_addr",     bus.address_output, 3);
    // start is ignored once halted
    bus.start = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    bus.start = 1'b0;
    check_val("p2_halt_hold",  bus.halted, 1);
    check_val("p2_count_hold", bus.cycle_count, 14);

    // Undefined opcode then HLT
    clear_mem();
    mem[0] = ins(5'b11111, 11'd0);
    mem[1] = ins(5'b00000, 11'd0);
    do_reset();
    run_trace(8);
    check_val("p3_acc_mask", acc_m, 32'h0);
    check_val("p3_ram_mask", ram_m, 32'h0);
    check_val("p3_addr_c4",  ad_tr[4], 1);
    check_val("p3_count",    bus.cycle_count, 6);
    check_val("p3_halted",   bus.halted, 1);

    // PC wrap through a memory full of NOPs
    for (int i = 0; i < 2048; i++) mem[i] = ins(5'b11111, 11'd0);
    do_reset();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    seen = 1'b0;
    wait_cnt = 0;
    while (bus.address_output != 11'd2047 && wait_cnt < 7000) begin
      seen = seen | bus.wr_acc | bus.wr_ram;
      tick();
      wait_cnt++;
    end
    check_val("p4_reach_2047", bus.address_output, 2047);
    wait_cnt = 0;
    while (bus.address_output == 11'd2047 && wait_cnt < 10) begin
      seen = seen | bus.wr_acc | bus.wr_ram;
      tick();
      wait_cnt++;
    end
    check_val("p4_wrap_addr",  bus.address_output, 0);
    check_val("p4_wrap_count", bus.cycle_count, 6144);
    check_val("p4_no_strobes", seen, 0);

    // Reset during OPERAND of ADD, then restart from address 0
    clear_mem();
    mem[0] = ins(5'b00100, 11'd5);
    mem[1] = ins(5'b00000, 11'd0);
    do_reset();
    run_trace(3);
    check_val("p5_da_operand", bus.data_addr, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("p5_rst_addr",   bus.address_output, 0);
    check_val("p5_rst_wr_acc", bus.wr_acc, 0);
    check_val("p5_rst_count",  bus.cycle_count, 0);
    check_val("p5_rst_da",     bus.data_addr, 0);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen = seen | bus.wr_acc;
    end
    check_val("p5_no_acc_in_rst", seen, 0);
    rst_n = 1'b1;
    tick();
    run_trace(8);
    check_val("p5_restart_addr", ad_tr[1], 0);
    check_val("p5_acc_mask",     acc_m, 32'h0000_0010);
    check_val("p5_sel_c4",       sel_tr[4], 2);
    check_val("p5_count",        bus.cycle_count, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
